r2r_phase_sequencer: RTL and testbench

- Downstream consumer of the two-phase, non-overlapping clock prescaler; sits between the digital sample source and the R2R ladder drive pins.
- Buffers incoming samples in a small FIFO.
- On each phase-0 strobe it fetches the next sample into a staging register; on each phase-1 strobe it commits the staged code to the ladder outputs.
- Fetch and commit never occur in the same cycle, so the ladder code changes only once per prescaler period.

---
 rtl/r2r_phase_sequencer.sv | 125 ++++++++++++
 tb/tb_r2r_phase_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2r_phase_sequencer.sv
// rtl/r2r_phase_sequencer.sv - sample FIFO, phase-0 fetch and phase-1 commit to R2R ladder code
module r2r_phase_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       phase0,
    input  logic                       phase1,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [WIDTH-1:0]           dac_code,
    output logic                       dac_update,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       underrun,
    output logic                       phase_err,
    input  logic                       clr_flags
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] staging;

    logic full;
    logic empty;
    logic fetch;
    logic commit;
    logic both_phases;
    logic do_push;
    logic do_pop;

    // Strobe decode: overlapping phases are a prescaler fault and do nothing but flag it.
    always_comb begin
        full        = (level == LW'(DEPTH));
        empty       = (level == '0);
        fetch       = phase0 && !phase1;
        commit      = phase1 && !phase0;
        both_phases = phase0 && phase1;
        do_push     = s_valid && !full;
        do_pop      = fetch && !empty;
        s_ready     = !full;
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; occupancy lives in level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy count; a push and pop in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Staging register: loads on fetch, keeps the last sample when the FIFO ran dry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging <= MIDSCALE;
        end else if (do_pop) begin
            staging <= mem[rd_ptr];
        end
    end

    // Ladder code and its update pulse; the pulse fires on every commit, changed value or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_code   <= MIDSCALE;
            dac_update <= 1'b0;
        end else begin
            dac_update <= commit;
            if (commit) begin
                dac_code <= staging;
            end
        end
    end

    // Sticky error flags; a clear wins over a coincident set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun  <= 1'b0;
            phase_err <= 1'b0;
        end else if (clr_flags) begin
            underrun  <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            if (fetch && empty) begin
                underrun <= 1'b1;
            end
            if (both_phases) begin
                phase_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_r2r_phase_sequencer.sv
// tb/tb_r2r_phase_sequencer.sv - scoreboard bench for r2r_phase_sequencer
module tb_r2r_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       phase0 = 1'b0;
    logic       phase1 = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       clr_flags = 1'b0;
    logic       s_ready;
    logic [7:0] dac_code;
    logic       dac_update;
    logic [2:0] level;
    logic       underrun;
    logic       phase_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_fifo [$];
    logic [7:0] exp_q [$];
    logic [7:0] m_stage = 8'h80;

    r2r_phase_sequencer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .phase0     (phase0),
        .phase1     (phase1),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .dac_code   (dac_code),
        .dac_update (dac_update),
        .level      (level),
        .underrun   (underrun),
        .phase_err  (phase_err),
        .clr_flags  (clr_flags)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO queue plus staging; each commit pushes the expected ladder code.
    always @(posedge clk or posedge rst) begin
        logic ok_push;
        if (rst) begin
            m_fifo.delete();
            exp_q.delete();
            m_stage = 8'h80;
        end else begin
            ok_push = s_valid && (m_fifo.size() < 4);
            if (phase0 && !phase1 && m_fifo.size() > 0) m_stage = m_fifo.pop_front();
            if (ok_push) m_fifo.push_back(s_data);
            if (phase1 && !phase0) exp_q.push_back(m_stage);
        end
    end

    // Scoreboard: pop on each dac_update pulse; also track occupancy.
    always @(negedge clk) begin
        logic [7:0] exp_code;
        if (!rst) begin
            vectors++;
            if (int'(level) !== m_fifo.size()) begin
                miscompares++;
                $display("FAIL sb_level: got %0d expected %0d at %0t", level, m_fifo.size(), $time);
            end
            if (dac_update) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_update: unexpected pulse, dac_code=%h at %0t", dac_code, $time);
                end else begin
                    exp_code = exp_q.pop_front();
                    if (dac_code !== exp_code) begin
                        miscompares++;
                        $display("FAIL sb_code: got %h expected %h at %0t", dac_code, exp_code, $time);
                    end
                end
            end else if (exp_q.size() != 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_missing_update: got no pulse expected %h at %0t", exp_q[0], $time);
                exp_q.delete();
            end
        end
    end

    task automatic step(input logic p0, input logic p1, input logic sv, input logic [7:0] sd, input logic clr);
        phase0 = p0;
        phase1 = p1;
        s_valid = sv;
        s_data = sd;
        clr_flags = clr;
        @(posedge clk);
        #1;
        phase0 = 1'b0;
        phase1 = 1'b0;
        s_valid = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 6;
        if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        if (dac_code !== 8'h80) begin miscompares++; $display("FAIL reset_dac_code: got %h expected 80", dac_code); end
        if (dac_update !== 1'b0) begin miscompares++; $display("FAIL reset_dac_update: got %b expected 0", dac_update); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        if (phase_err !== 1'b0) begin miscompares++; $display("FAIL reset_phase_err: got %b expected 0", phase_err); end
    endtask

    task automatic test_idle_strobes();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step((c % 4) == 1, (c % 4) == 3, 1'b0, 8'h00, 1'b0);
            if (c == 1) begin
                vectors++;
                if (underrun !== 1'b1) begin miscompares++; $display("FAIL idle_underrun: got %b expected 1", underrun); end
            end
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        vectors++;
        if (dac_code !== 8'h80) begin miscompares++; $display("FAIL idle_dac_code: got %h expected 80", dac_code); end
    endtask

    task automatic test_stream();
        logic [7:0] sd;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            sd = (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : 8'h33;
            step((c % 4) == 1, (c % 4) == 3, c < 3, sd, 1'b0);
            if (c == 3 || c == 7 || c == 11) begin
                vectors++;
                if (dac_code !== sd * 0 + ((c == 3) ? 8'h11 : (c == 7) ? 8'h22 : 8'h33)) begin
                    miscompares++;
                    $display("FAIL stream_dac_code: got %h at cycle %0d", dac_code, c + 1);
                end
            end
            if (c == 12) begin
                vectors++;
                if (underrun !== 1'b0) begin miscompares++; $display("FAIL stream_underrun_early: got %b expected 0", underrun); end
            end
            if (c == 13) begin
                vectors++;
                if (underrun !== 1'b1) begin miscompares++; $display("FAIL stream_underrun: got %b expected 1", underrun); end
            end
        end
        vectors++;
        if (dac_code !== 8'h33) begin miscompares++; $display("FAIL stream_hold: got %h expected 33", dac_code); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
            if (i == 3) begin
                vectors += 2;
                if (s_ready !== 1'b0) begin miscompares++; $display("FAIL full_s_ready: got %b expected 0", s_ready); end
                if (level !== 3'd4) begin miscompares++; $display("FAIL full_level: got %0d expected 4", level); end
            end
        end
        vectors++;
        if (level !== 3'd4) begin miscompares++; $display("FAIL full_overflow_level: got %0d expected 4", level); end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        vectors += 2;
        if (level !== 3'd3) begin miscompares++; $display("FAIL full_pop_level: got %0d expected 3", level); end
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL full_pop_s_ready: got %b expected 1", s_ready); end
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        vectors++;
        if (dac_code !== 8'hA3) begin miscompares++; $display("FAIL full_drain_code: got %h expected a3", dac_code); end
    endtask

    task automatic test_push_pop_empty();
        do_reset();
        step(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0);
        vectors += 2;
        if (underrun !== 1'b1) begin miscompares++; $display("FAIL ppe_underrun: got %b expected 1", underrun); end
        if (level !== 3'd1) begin miscompares++; $display("FAIL ppe_level: got %0d expected 1", level); end
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        vectors++;
        if (dac_code !== 8'h80) begin miscompares++; $display("FAIL ppe_staging_kept: got %h expected 80", dac_code); end
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        vectors++;
        if (level !== 3'd0) begin miscompares++; $display("FAIL ppe_second_pop: got %0d expected 0", level); end
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        vectors++;
        if (dac_code !== 8'h5A) begin miscompares++; $display("FAIL ppe_code: got %h expected 5a", dac_code); end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_phase_err();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        vectors += 3;
        if (phase_err !== 1'b1) begin miscompares++; $display("FAIL perr_set: got %b expected 1", phase_err); end
        if (level !== 3'd1) begin miscompares++; $display("FAIL perr_level: got %0d expected 1", level); end
        if (dac_code !== 8'h80) begin miscompares++; $display("FAIL perr_code: got %h expected 80", dac_code); end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        vectors += 2;
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL perr_clr_underrun: got %b expected 0", underrun); end
        if (phase_err !== 1'b0) begin miscompares++; $display("FAIL perr_clr_phase_err: got %b expected 0", phase_err); end
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        vectors++;
        if (phase_err !== 1'b0) begin miscompares++; $display("FAIL perr_clr_priority: got %b expected 0", phase_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h44, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h66, 1'b0);
        vectors += 2;
        if (level !== 3'd3) begin miscompares++; $display("FAIL mid_pre_level: got %0d expected 3", level); end
        if (dac_code !== 8'h33) begin miscompares++; $display("FAIL mid_pre_code: got %h expected 33", dac_code); end
        #3;
        rst = 1'b1;
        #1;
        vectors += 5;
        if (level !== 3'd0) begin miscompares++; $display("FAIL mid_level: got %0d expected 0", level); end
        if (dac_code !== 8'h80) begin miscompares++; $display("FAIL mid_code: got %h expected 80", dac_code); end
        if (s_ready !== 1'b1) begin miscompares++; $display("FAIL mid_s_ready: got %b expected 1", s_ready); end
        if (underrun !== 1'b0) begin miscompares++; $display("FAIL mid_underrun: got %b expected 0", underrun); end
        if (phase_err !== 1'b0) begin miscompares++; $display("FAIL mid_phase_err: got %b expected 0", phase_err); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        vectors++;
        if (dac_code !== 8'h80) begin miscompares++; $display("FAIL mid_after_code: got %h expected 80", dac_code); end
    endtask

    initial begin
        test_reset();
        test_idle_strobes();
        test_stream();
        test_full();
        test_push_pop_empty();
        test_phase_err();
        test_reset_mid();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
